// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and decode-side training signals shared by the predictor and its user.
// The predictor takes the slave view; the fetch/decode logic takes the master view.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int GHR_W  = 4
);
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [GHR_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_mispredict;
  logic              flush_all;

  modport master (
    output lookup_valid, lookup_pc,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_mispredict,
    output flush_all
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    output pred_hit, pred_taken, pred_target, pred_ghr,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_mispredict,
    input  flush_all
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters; bimodal or gshare indexing.
// Lookup is combinational from the fetch PC; training arrives from decode one clock edge later.
module branch_predictor_btb #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int MODE   = 0,
  parameter int GHR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predictor_btb_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_ALLOC - CNT_W'(1);

  if (GHR_W > IDX_W || GHR_W < 1 || CNT_W < 1 || CNT_W > 4) begin : g_param_err
    $error("branch_predictor_btb: illegal GHR_W/CNT_W parameterisation");
  end

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [GHR_W-1:0]  ghr_q, ghr_d;

  function automatic logic [IDX_W-1:0] calc_idx(input logic [ADDR_W-1:0] pc,
                                                input logic [GHR_W-1:0]  ghr);
    logic [IDX_W-1:0] idx;
    idx = pc[IDX_W+1:2];
    if (MODE != 0) idx = idx ^ IDX_W'(ghr);
    return idx;
  endfunction

  // Lookup side: reads registered state only, so a same-cycle update is not visible here.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  always_comb begin
    lk_idx   = calc_idx(bus.lookup_pc, ghr_q);
    lk_tag   = bus.lookup_pc[ADDR_W-1:IDX_W+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];
  end

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_taken;
  assign bus.pred_target = lk_taken ? target_q[lk_idx] : bus.lookup_pc + ADDR_W'(4);
  assign bus.pred_ghr    = ghr_q;

  // Update side: indexed with the history the branch was predicted under, not the live GHR.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             alloc;
  logic             cnt_we;
  logic             tgt_we;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    up_idx   = calc_idx(bus.upd_pc, bus.upd_ghr);
    up_tag   = bus.upd_pc[ADDR_W-1:IDX_W+2];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    alloc    = bus.upd_valid && !up_hit && bus.upd_taken;
    cnt_we   = bus.upd_valid && (up_hit || bus.upd_taken);
    tgt_we   = bus.upd_valid && bus.upd_taken;
    cnt_next = CNT_ALLOC;
    if (up_hit) begin
      if (bus.upd_taken) begin
        cnt_next = (cnt_q[up_idx] == CNT_MAX) ? CNT_MAX : cnt_q[up_idx] + CNT_W'(1);
      end else begin
        cnt_next = (cnt_q[up_idx] == '0) ? '0 : cnt_q[up_idx] - CNT_W'(1);
      end
    end
  end

  // Flush only clears valid bits; the counter write of a coincident update still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else begin
      if (cnt_we) cnt_q[up_idx] <= cnt_next;
      if (bus.flush_all) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (alloc) begin
        valid_q[up_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc)  tag_q[up_idx]    <= up_tag;
    if (tgt_we) target_q[up_idx] <= bus.upd_target;
  end

  // Mispredict repair outranks the speculative shift from the current lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (MODE != 0) begin
      if (bus.upd_valid && bus.upd_mispredict) begin
        ghr_d = GHR_W'({bus.upd_ghr, bus.upd_taken});
      end else if (bus.lookup_valid && lk_hit) begin
        ghr_d = GHR_W'({ghr_q, lk_taken});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0], bus.upd_mispredict,
                         bus.lookup_valid, bus.upd_ghr};

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed check of the predictor: a bimodal instance driven from a vector table and a
// gshare instance driven by a hand-written history/repair/reset sequence.
module tb_branch_predictor_btb;

  logic clk;
  logic rst_n;

  branch_predictor_btb_if #(.ADDR_W(32), .GHR_W(4)) bus0 ();
  branch_predictor_btb_if #(.ADDR_W(32), .GHR_W(4)) bus1 ();

  branch_predictor_btb #(.ADDR_W(32), .IDX_W(4), .CNT_W(2), .MODE(0), .GHR_W(4)) u_bim (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  branch_predictor_btb #(.ADDR_W(32), .IDX_W(4), .CNT_W(2), .MODE(1), .GHR_W(4)) u_gsh (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lkv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        fl;
    logic        eh;
    logic        et;
    logic [31:0] eg;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic lkv, input logic [31:0] lpc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utg, input logic fl,
                              input logic eh, input logic et, input logic [31:0] eg);
    vec_t v;
    v = '{lkv, lpc, uv, upc, ut, utg, fl, eh, et, eg};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle1();
    bus1.lookup_valid = 0; bus1.lookup_pc = 0; bus1.upd_valid = 0; bus1.upd_pc = 0;
    bus1.upd_taken = 0; bus1.upd_target = 0; bus1.upd_ghr = 0; bus1.upd_mispredict = 0;
    bus1.flush_all = 0;
  endtask

  // One gshare cycle: drive inputs after the falling edge, sample 1 time unit later.
  task automatic g_step(input logic lkv, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic [3:0] ughr, input logic mp);
    @(negedge clk);
    bus1.lookup_valid = lkv; bus1.lookup_pc = lpc; bus1.upd_valid = uv; bus1.upd_pc = upc;
    bus1.upd_taken = ut; bus1.upd_target = utg; bus1.upd_ghr = ughr; bus1.upd_mispredict = mp;
    #1;
    $display("gshare lk=%b pc=%h upd=%b upc=%h t=%b ghr_in=%b mp=%b -> hit=%b tk=%b tgt=%h ghr=%b",
             lkv, lpc, uv, upc, ut, ughr, mp, bus1.pred_hit, bus1.pred_taken,
             bus1.pred_target, bus1.pred_ghr);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0;
    bus0.lookup_valid = 0; bus0.lookup_pc = 0; bus0.upd_valid = 0; bus0.upd_pc = 0;
    bus0.upd_taken = 0; bus0.upd_target = 0; bus0.upd_ghr = 0; bus0.upd_mispredict = 0;
    bus0.flush_all = 0;
    idle1();

    //  lkv lpc            uv upc           ut utg           fl   eh et eg
    add(1, 32'hBFC00000, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'hBFC00004);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 0,   0, 0, 32'h00000104);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 0,   1, 1, 32'h00000200);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 0,   1, 1, 32'h00000200);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 0,   1, 1, 32'h00000200);
    add(1, 32'h00000100, 1, 32'h00000100, 0, 32'h0,        0,   1, 1, 32'h00000200);
    add(1, 32'h00000100, 1, 32'h00000100, 0, 32'h0,        0,   1, 1, 32'h00000200);
    add(1, 32'h00000100, 1, 32'h00000100, 0, 32'h0,        0,   1, 0, 32'h00000104);
    add(1, 32'h00000100, 1, 32'h00000100, 0, 32'h0,        0,   1, 0, 32'h00000104);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 0,   1, 0, 32'h00000104);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000200, 0,   1, 0, 32'h00000104);
    add(1, 32'h00000100, 1, 32'h00000100, 1, 32'h00000240, 0,   1, 1, 32'h00000200);
    add(1, 32'h00000100, 0, 32'h0,        0, 32'h0,        0,   1, 1, 32'h00000240);
    add(1, 32'h00000140, 1, 32'h00000140, 1, 32'h00000300, 0,   0, 0, 32'h00000144);
    add(1, 32'h00000100, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h00000104);
    add(1, 32'h00000140, 0, 32'h0,        0, 32'h0,        0,   1, 1, 32'h00000300);
    add(1, 32'h00000180, 1, 32'h00000180, 0, 32'h0,        0,   0, 0, 32'h00000184);
    add(1, 32'h00000140, 0, 32'h0,        0, 32'h0,        0,   1, 1, 32'h00000300);
    add(1, 32'h00000180, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h00000184);
    add(1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h00000000);
    add(1, 32'h00000104, 1, 32'h00000104, 1, 32'h00000500, 0,   0, 0, 32'h00000108);
    add(1, 32'h00000104, 0, 32'h0,        0, 32'h0,        0,   1, 1, 32'h00000500);
    add(1, 32'h00000104, 1, 32'h00000104, 1, 32'h00000500, 1,   1, 1, 32'h00000500);
    add(1, 32'h00000104, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h00000108);
    add(1, 32'h00000140, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h00000144);
    add(1, 32'h00000104, 1, 32'h00000104, 1, 32'h00000504, 0,   0, 0, 32'h00000108);
    add(1, 32'h00000104, 0, 32'h0,        0, 32'h0,        0,   1, 1, 32'h00000504);
    add(0, 32'h00000000, 1, 32'h00000100, 1, 32'h00000700, 0,   0, 0, 32'h00000004);
    add(1, 32'h80000100, 0, 32'h0,        0, 32'h0,        0,   0, 0, 32'h80000104);
    add(1, 32'h00000100, 0, 32'h0,        0, 32'h0,        0,   1, 1, 32'h00000700);

    repeat (3) @(negedge clk);
    #1;
    check("reset_bim_ghr", {60'd0, bus0.pred_ghr}, 64'd0);
    check("reset_gsh_ghr", {60'd0, bus1.pred_ghr}, 64'd0);
    rst_n = 1'b1;

    // Bimodal table: outputs sampled before the edge reflect pre-update state.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus0.lookup_valid = vecs[i].lkv; bus0.lookup_pc = vecs[i].lpc;
      bus0.upd_valid = vecs[i].uv; bus0.upd_pc = vecs[i].upc; bus0.upd_taken = vecs[i].ut;
      bus0.upd_target = vecs[i].utg; bus0.flush_all = vecs[i].fl;
      #1;
      $display("vec %0d lookup=%h upd=%b/%h/%b -> hit=%b tk=%b tgt=%h", i, vecs[i].lpc,
               vecs[i].uv, vecs[i].upc, vecs[i].ut, bus0.pred_hit, bus0.pred_taken,
               bus0.pred_target);
      check($sformatf("bim_vec%0d", i),
            {30'd0, bus0.pred_hit, bus0.pred_taken, bus0.pred_target},
            {30'd0, vecs[i].eh, vecs[i].et, vecs[i].eg});
    end
    @(negedge clk);
    bus0.upd_valid = 0; bus0.flush_all = 0; bus0.lookup_valid = 1; bus0.lookup_pc = 32'h100;
    #1;
    check("bim_ghr_stays_0", {60'd0, bus0.pred_ghr}, 64'd0);

    // Gshare: train idx0 (pc 0x100) and idx1 (pc 0x104) with history 0.
    g_step(0, 32'h100, 1, 32'h100, 1, 32'h200, 4'b0000, 0);
    g_step(0, 32'h100, 1, 32'h104, 1, 32'h600, 4'b0000, 0);
    g_step(1, 32'h100, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_hit1", {27'd0, bus1.pred_hit, bus1.pred_taken, bus1.pred_ghr, bus1.pred_target},
          {27'd0, 1'b1, 1'b1, 4'b0000, 32'h200});
    g_step(1, 32'h100, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_hit2", {27'd0, bus1.pred_hit, bus1.pred_taken, bus1.pred_ghr, bus1.pred_target},
          {27'd0, 1'b1, 1'b1, 4'b0001, 32'h600});
    g_step(0, 32'h100, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_ghr_0011", {60'd0, bus1.pred_ghr}, {60'd0, 4'b0011});
    // Repair coincides with a taken hit (0x10C ^ 0011 -> idx0); repair must win.
    g_step(1, 32'h10C, 1, 32'h100, 0, 32'h0, 4'b0001, 1);
    check("gsh_hit_during_repair", {30'd0, bus1.pred_hit, bus1.pred_taken, bus1.pred_target},
          {30'd0, 1'b1, 1'b1, 32'h200});
    g_step(1, 32'h100, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_repair_ghr", {59'd0, bus1.pred_hit, bus1.pred_ghr}, {59'd0, 1'b0, 4'b0010});
    // Miss lookup held the GHR; 0x10C ^ 0010 -> idx1, whose counter was trained down to 1.
    g_step(0, 32'h10C, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_hold_idx1", {27'd0, bus1.pred_hit, bus1.pred_taken, bus1.pred_ghr, bus1.pred_target},
          {27'd0, 1'b1, 1'b0, 4'b0010, 32'h110});

    // Asynchronous reset mid-cycle with an update pending: update must be discarded.
    g_step(1, 32'h10C, 1, 32'h10C, 1, 32'h900, 4'b0010, 1);
    #2 rst_n = 1'b0;
    #1;
    check("gsh_async_rst", {27'd0, bus1.pred_hit, bus1.pred_taken, bus1.pred_ghr, bus1.pred_target},
          {27'd0, 1'b0, 1'b0, 4'b0000, 32'h110});
    @(negedge clk);
    idle1();
    rst_n = 1'b1;
    g_step(1, 32'h100, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_post_rst_100", {59'd0, bus1.pred_hit, bus1.pred_ghr}, {59'd0, 1'b0, 4'b0000});
    g_step(1, 32'h104, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_post_rst_104", {59'd0, bus1.pred_hit, bus1.pred_ghr}, {59'd0, 1'b0, 4'b0000});
    g_step(1, 32'h10C, 0, 32'h0, 0, 32'h0, 4'b0000, 0);
    check("gsh_post_rst_10c", {31'd0, bus1.pred_hit, bus1.pred_target}, {31'd0, 1'b0, 32'h110});
    check("bim_post_rst", {31'd0, bus0.pred_hit, bus0.pred_target}, {31'd0, 1'b0, 32'h104});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
